pia_host_sequencer: RTL and testbench

- Bus-side controller for the 6821-style PIA on the sound board.
- After reset it runs a fixed configuration program: DDRs, control registers, initial port B output.
- It then shares the PIA register port between two requesters (round-robin) and an automatic IRQ-A service engine. The engine reads port A on interrupt and hands the byte off as a command.
- Sits between the sound CPU/debug master and the PIA; owns PIA cs/rw/addr/data_in.

---
 rtl/pia_ctrl_pkg.sv | 62 ++++++
 rtl/pia_host_sequencer_arb.sv | 47 ++++
 rtl/pia_host_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_pia_host_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pia_ctrl_pkg.sv
// Purpose: shared constants and helpers for the sound-board PIA host sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pia_ctrl_pkg;

   // Sequencer states (legacy-compatible encoding)
   localparam logic [2:0] ST_INIT_ISSUE = 3'd0;
   localparam logic [2:0] ST_INIT_GAP   = 3'd1;
   localparam logic [2:0] ST_IDLE       = 3'd2;
   localparam logic [2:0] ST_ACCESS     = 3'd3;
   localparam logic [2:0] ST_RECOVER    = 3'd4;

   // PIA register select values
   localparam logic [1:0] ADDR_ORA_DDRA = 2'd0;
   localparam logic [1:0] ADDR_CRA      = 2'd1;
   localparam logic [1:0] ADDR_ORB_DDRB = 2'd2;
   localparam logic [1:0] ADDR_CRB      = 2'd3;

   // Control-register bit that switches addr 0/2 from DDR to data port
   localparam int         CR_DDR_SEL      = 2;
   localparam logic [5:0] CR_DDR_SEL_MASK = 6'h04;

   // Configuration program length and last step index
   localparam int         INIT_STEPS = 7;
   localparam logic [2:0] INIT_LAST  = 3'(INIT_STEPS - 1);

   // Owner of the access currently in flight
   localparam logic [1:0] OWN_REQ0 = 2'd0;
   localparam logic [1:0] OWN_REQ1 = 2'd1;
   localparam logic [1:0] OWN_IRQ  = 2'd2;

   typedef struct packed {
      logic [1:0] addr;
      logic [7:0] data;
   } pia_wr_t;

   // Register write performed at each step of the configuration program.
   // CRA/CRB are first cleared so the DDRs are addressable, then restored
   // with the DDR-select bit set so addr 0/2 reach the data ports.
   function automatic pia_wr_t init_step(input logic [2:0] step,
                                         input logic [7:0] ddra,
                                         input logic [7:0] ddrb,
                                         input logic [7:0] orb,
                                         input logic [5:0] cra,
                                         input logic [5:0] crb);
      pia_wr_t w;
      w.addr = ADDR_CRA;
      w.data = 8'h00;
      case (step)
         3'd0: begin w.addr = ADDR_CRA;      w.data = 8'h00;                            end
         3'd1: begin w.addr = ADDR_ORA_DDRA; w.data = ddra;                             end
         3'd2: begin w.addr = ADDR_CRA;      w.data = {2'b00, cra | CR_DDR_SEL_MASK};   end
         3'd3: begin w.addr = ADDR_CRB;      w.data = 8'h00;                            end
         3'd4: begin w.addr = ADDR_ORB_DDRB; w.data = ddrb;                             end
         3'd5: begin w.addr = ADDR_CRB;      w.data = {2'b00, crb | CR_DDR_SEL_MASK};   end
         3'd6: begin w.addr = ADDR_ORB_DDRB; w.data = orb;                              end
         default: begin w.addr = ADDR_CRA;   w.data = 8'h00;                            end
      endcase
      return w;
   endfunction

endpackage

// File: rtl/pia_host_sequencer_arb.sv
// Purpose: 2-way round-robin arbiter for the PIA requester ports.
// Latency: grant is combinational from valid/en; pointer updates on the advance edge.
// Backpressure: no grant while en is low; losers simply see no grant.
module pia_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       en,
   input  logic       adv,
   output logic [1:0] grant,
   output logic       ptr
);

   logic ptr_q;
   logic ptr_d;

   // Pick the pointed-to requester first, fall back to the other one
   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (!ptr_q) begin
            if (valid[0])      grant = 2'b01;
            else if (valid[1]) grant = 2'b10;
         end else begin
            if (valid[1])      grant = 2'b10;
            else if (valid[0]) grant = 2'b01;
         end
      end
   end

   // After a grant, point at whichever requester did not win
   always_comb begin
      ptr_d = ptr_q;
      if (adv && (grant != 2'b00)) begin
         ptr_d = grant[0];
      end
   end

   // Pointer register, reset to requester 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/pia_host_sequencer.sv
// Purpose: PIA bus master: runs the init program, then arbitrates IRQ-A service and two requesters.
// Latency: requester ready at T, PIA cs at T+1, rsp at T+2; one access every 3 cycles.
// Backpressure: requesters hold valid until ready; commands are overwritten (flagged) if not acked.
module pia_host_sequencer
   import pia_ctrl_pkg::*;
#(
   parameter logic [7:0] P_DDRA      = 8'h00,
   parameter logic [7:0] P_DDRB      = 8'hFF,
   parameter logic [5:0] P_CRA       = 6'h3D,
   parameter logic [5:0] P_CRB       = 6'h3C,
   parameter logic [7:0] P_ORB       = 8'h00,
   parameter bit         P_AUTO_IRQA = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pia_cs,
   output logic       pia_rw,
   output logic [1:0] pia_addr,
   output logic [7:0] pia_wdata,
   input  logic [7:0] pia_rdata,
   input  logic       pia_irqa,
   input  logic       req0_valid,
   input  logic       req0_rw,
   input  logic [1:0] req0_addr,
   input  logic [7:0] req0_wdata,
   output logic       req0_ready,
   output logic       rsp0_valid,
   input  logic       req1_valid,
   input  logic       req1_rw,
   input  logic [1:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic       req1_ready,
   output logic       rsp1_valid,
   output logic [7:0] rsp_rdata,
   output logic       init_done,
   output logic       cmd_valid,
   output logic [7:0] cmd_data,
   input  logic       cmd_ack,
   output logic       cmd_overrun
);

   logic [2:0] state_q, state_d;
   logic [2:0] step_q, step_d;
   logic [1:0] own_q, own_d;
   logic       lat_rw_q, lat_rw_d;
   logic [1:0] lat_addr_q, lat_addr_d;
   logic [7:0] lat_wdata_q, lat_wdata_d;
   // Only the DDR-select bit of the CRA shadow influences sequencing
   logic       shadow_ddr_sel_q, shadow_ddr_sel_d;
   logic       init_done_q, init_done_d;
   logic       cmd_valid_q, cmd_valid_d;
   logic [7:0] cmd_data_q, cmd_data_d;
   logic       cmd_overrun_q, cmd_overrun_d;
   logic [7:0] rsp_rdata_q, rsp_rdata_d;

   logic       irq_go;
   logic       arb_en;
   logic [1:0] arb_grant;
   logic       arb_ptr;
   logic       capture;
   logic       bus_on;
   pia_wr_t    init_wr;

   // Arbitration qualifiers and the current init-program write
   always_comb begin
      irq_go  = P_AUTO_IRQA && pia_irqa && shadow_ddr_sel_q;
      arb_en  = (state_q == ST_IDLE) && !irq_go;
      init_wr = init_step(step_q, P_DDRA, P_DDRB, P_ORB, P_CRA, P_CRB);
   end

   pia_rr_arb u_arb (
      .clk   (clk),
      .rst   (rst),
      .valid ({req1_valid, req0_valid}),
      .en    (arb_en),
      .adv   (arb_en),
      .grant (arb_grant),
      .ptr   (arb_ptr)
   );

   // Main sequencer: init program, arbitration, access/recover pacing
   always_comb begin
      state_d          = state_q;
      step_d           = step_q;
      own_d            = own_q;
      lat_rw_d         = lat_rw_q;
      lat_addr_d       = lat_addr_q;
      lat_wdata_d      = lat_wdata_q;
      shadow_ddr_sel_d = shadow_ddr_sel_q;
      init_done_d      = init_done_q;
      rsp_rdata_d      = rsp_rdata_q;
      case (state_q)
         ST_INIT_ISSUE: begin
            if (init_wr.addr == ADDR_CRA) shadow_ddr_sel_d = init_wr.data[CR_DDR_SEL];
            state_d = ST_INIT_GAP;
         end
         ST_INIT_GAP: begin
            if (step_q == INIT_LAST) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else begin
               step_d  = step_q + 3'd1;
               state_d = ST_INIT_ISSUE;
            end
         end
         ST_IDLE: begin
            if (irq_go) begin
               // Reading port A clears the PIA interrupt flags
               own_d       = OWN_IRQ;
               lat_rw_d    = 1'b1;
               lat_addr_d  = ADDR_ORA_DDRA;
               lat_wdata_d = 8'h00;
               state_d     = ST_ACCESS;
            end else if (arb_grant[0]) begin
               own_d       = OWN_REQ0;
               lat_rw_d    = req0_rw;
               lat_addr_d  = req0_addr;
               lat_wdata_d = req0_wdata;
               state_d     = ST_ACCESS;
            end else if (arb_grant[1]) begin
               own_d       = OWN_REQ1;
               lat_rw_d    = req1_rw;
               lat_addr_d  = req1_addr;
               lat_wdata_d = req1_wdata;
               state_d     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RECOVER;
            if (own_q != OWN_IRQ) begin
               if (lat_rw_q) rsp_rdata_d = pia_rdata;
               else if (lat_addr_q == ADDR_CRA) shadow_ddr_sel_d = lat_wdata_q[CR_DDR_SEL];
            end
         end
         ST_RECOVER: begin
            // Gap cycle lets irqa fall before the next arbitration
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT_ISSUE;
            step_d  = 3'd0;
         end
      endcase
   end

   // Command capture and consumer handshake; a same-edge capture beats the ack
   always_comb begin
      cmd_valid_d   = cmd_valid_q;
      cmd_data_d    = cmd_data_q;
      cmd_overrun_d = cmd_overrun_q;
      capture       = (state_q == ST_ACCESS) && (own_q == OWN_IRQ);
      if (capture) begin
         cmd_valid_d = 1'b1;
         cmd_data_d  = pia_rdata;
         if (cmd_valid_q && !cmd_ack)     cmd_overrun_d = 1'b1;
         else if (cmd_valid_q && cmd_ack) cmd_overrun_d = 1'b0;
      end else if (cmd_valid_q && cmd_ack) begin
         cmd_valid_d   = 1'b0;
         cmd_overrun_d = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_INIT_ISSUE;
         step_q           <= 3'd0;
         own_q            <= OWN_REQ0;
         lat_rw_q         <= 1'b1;
         lat_addr_q       <= 2'd0;
         lat_wdata_q      <= 8'h00;
         shadow_ddr_sel_q <= 1'b0;
         init_done_q      <= 1'b0;
         cmd_valid_q      <= 1'b0;
         cmd_data_q       <= 8'h00;
         cmd_overrun_q    <= 1'b0;
         rsp_rdata_q      <= 8'h00;
      end else begin
         state_q          <= state_d;
         step_q           <= step_d;
         own_q            <= own_d;
         lat_rw_q         <= lat_rw_d;
         lat_addr_q       <= lat_addr_d;
         lat_wdata_q      <= lat_wdata_d;
         shadow_ddr_sel_q <= shadow_ddr_sel_d;
         init_done_q      <= init_done_d;
         cmd_valid_q      <= cmd_valid_d;
         cmd_data_q       <= cmd_data_d;
         cmd_overrun_q    <= cmd_overrun_d;
         rsp_rdata_q      <= rsp_rdata_d;
      end
   end

   // PIA bus drive; qualified by rst so an in-flight access is dropped at once
   always_comb begin
      bus_on    = ((state_q == ST_INIT_ISSUE) || (state_q == ST_ACCESS)) && !rst;
      pia_cs    = bus_on;
      pia_rw    = 1'b1;
      pia_addr  = 2'd0;
      pia_wdata = 8'h00;
      if (bus_on) begin
         if (state_q == ST_INIT_ISSUE) begin
            pia_rw    = 1'b0;
            pia_addr  = init_wr.addr;
            pia_wdata = init_wr.data;
         end else begin
            pia_rw    = lat_rw_q;
            pia_addr  = lat_addr_q;
            pia_wdata = lat_rw_q ? 8'h00 : lat_wdata_q;
         end
      end
   end

   assign req0_ready  = arb_grant[0];
   assign req1_ready  = arb_grant[1];
   assign rsp0_valid  = (state_q == ST_RECOVER) && (own_q == OWN_REQ0);
   assign rsp1_valid  = (state_q == ST_RECOVER) && (own_q == OWN_REQ1);
   assign rsp_rdata   = rsp_rdata_q;
   assign init_done   = init_done_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_data    = cmd_data_q;
   assign cmd_overrun = cmd_overrun_q;

   // With both requesters waiting, the one under the pointer must win
   assert property (@(posedge clk) disable iff (rst)
                    (arb_en && req0_valid && req1_valid) |-> arb_grant[arb_ptr]);

endmodule

// File: tb/tb_pia_host_sequencer.sv
module tb_pia_host_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       pia_cs, pia_rw;
   logic [1:0] pia_addr;
   logic [7:0] pia_wdata, pia_rdata;
   logic       pia_irqa;
   logic       req0_valid, req0_rw, req1_valid, req1_rw;
   logic [1:0] req0_addr, req1_addr;
   logic [7:0] req0_wdata, req1_wdata;
   logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [7:0] rsp_rdata;
   logic       init_done, cmd_valid, cmd_ack, cmd_overrun;
   logic [7:0] cmd_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pia_host_sequencer dut (
      .clk(clk), .rst(rst),
      .pia_cs(pia_cs), .pia_rw(pia_rw), .pia_addr(pia_addr), .pia_wdata(pia_wdata),
      .pia_rdata(pia_rdata), .pia_irqa(pia_irqa),
      .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
      .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
      .rsp_rdata(rsp_rdata), .init_done(init_done),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ack(cmd_ack), .cmd_overrun(cmd_overrun)
   );

   // ---------------- 6821 PIA model ----------------
   logic [7:0] m_ddra, m_ddrb, m_orb, pa_i, pb_o;
   logic [5:0] m_cra, m_crb;
   logic       m_flag, ca1_pulse;
   int         rd0_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ddra <= 8'h00; m_ddrb <= 8'h00; m_orb <= 8'h00;
         m_cra  <= 6'h00; m_crb  <= 6'h00; m_flag <= 1'b0;
      end else begin
         if (pia_cs && !pia_rw) begin
            case (pia_addr)
               2'd0: if (!m_cra[2]) m_ddra <= pia_wdata;
               2'd1: m_cra <= pia_wdata[5:0];
               2'd2: if (m_crb[2]) m_orb <= pia_wdata; else m_ddrb <= pia_wdata;
               default: m_crb <= pia_wdata[5:0];
            endcase
         end
         if (pia_cs && pia_rw && pia_addr == 2'd0 && m_cra[2]) m_flag <= 1'b0;
         else if (ca1_pulse) m_flag <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (pia_cs && pia_rw && pia_addr == 2'd0) rd0_cnt <= rd0_cnt + 1;
   end

   always_comb begin
      case (pia_addr)
         2'd0:    pia_rdata = m_cra[2] ? pa_i : m_ddra;
         2'd1:    pia_rdata = {m_flag, 1'b0, m_cra};
         2'd2:    pia_rdata = m_crb[2] ? m_orb : m_ddrb;
         default: pia_rdata = {2'b00, m_crb};
      endcase
   end

   assign pia_irqa = m_flag && m_cra[0];
   assign pb_o     = m_orb;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
   } init_vec_t;
   init_vec_t init_tab[7];

   typedef struct {
      int         port;
      logic       rw;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic [7:0] pa;
      logic [7:0] exp_rd;
      logic [7:0] exp_pb;
   } req_vec_t;
   req_vec_t req_tab[6];

   // Starts in cycle 0 after reset release (called at posedge+1)
   task automatic check_init();
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c % 2 == 0) begin
            check("init_cs", pia_cs, 1);
            check("init_rw", pia_rw, 0);
            check("init_addr", pia_addr, init_tab[c/2].addr);
            check("init_data", pia_wdata, init_tab[c/2].data);
         end else begin
            check("init_gap_cs", pia_cs, 0);
         end
         if (c == 13) check("init_done_early", init_done, 0);
      end
      @(negedge clk);
      check("init_done_14", init_done, 1);
      check("pia_ddra", m_ddra, 8'h00);
      check("pia_cra", m_cra, 6'h3D);
      check("pia_ddrb", m_ddrb, 8'hFF);
      check("pia_crb", m_crb, 6'h3C);
      check("pia_orb", m_orb, 8'h00);
      @(posedge clk); #1;
   endtask

   // Entered and left at posedge+1
   task automatic do_req(input int port, input logic rw, input logic [1:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd);
      logic got;
      got = 1'b0;
      if (port == 0) begin
         req0_rw = rw; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
      end else begin
         req1_rw = rw; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
      end
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if ((port == 0) ? req0_ready : req1_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("req_grant", got, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (got) begin
         @(negedge clk);
         check("acc_cs", pia_cs, 1);
         check("acc_rw", pia_rw, rw);
         check("acc_addr", pia_addr, addr);
         if (!rw) check("acc_wdata", pia_wdata, wdata);
         @(negedge clk);
         check("rsp_valid", (port == 0) ? rsp0_valid : rsp1_valid, 1);
         check("rsp_cs_gap", pia_cs, 0);
         if (rw) check("rsp_rdata", rsp_rdata, exp_rd);
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_ca1(input logic [7:0] pa);
      @(posedge clk); #1;
      pa_i = pa;
      ca1_pulse = 1'b1;
      @(posedge clk); #1;
      ca1_pulse = 1'b0;
   endtask

   // Returns at the negedge inside the IRQ read access
   task automatic wait_irq_read(output logic seen);
      seen = 1'b0;
      for (int w = 0; w < 12; w++) begin
         @(negedge clk);
         if (pia_cs && pia_rw && pia_addr == 2'd0) begin
            seen = 1'b1;
            break;
         end
      end
      check("irq_read_seen", seen, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      int   base;
      init_tab[0] = '{2'd1, 8'h00};
      init_tab[1] = '{2'd0, 8'h00};
      init_tab[2] = '{2'd1, 8'h3D};
      init_tab[3] = '{2'd3, 8'h00};
      init_tab[4] = '{2'd2, 8'hFF};
      init_tab[5] = '{2'd3, 8'h3C};
      init_tab[6] = '{2'd2, 8'h00};
      //              port rw addr wdata  pa     exp_rd exp_pb
      req_tab[0] = '{0, 1'b0, 2'd2, 8'hA5, 8'h00, 8'h00, 8'hA5};
      req_tab[1] = '{1, 1'b1, 2'd2, 8'h00, 8'h00, 8'hA5, 8'hA5};
      req_tab[2] = '{0, 1'b0, 2'd2, 8'h3C, 8'h00, 8'h00, 8'h3C};
      req_tab[3] = '{1, 1'b1, 2'd3, 8'h00, 8'h00, 8'h3C, 8'h3C};
      req_tab[4] = '{0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h3D, 8'h3C};
      req_tab[5] = '{1, 1'b1, 2'd0, 8'h00, 8'h5A, 8'h5A, 8'h3C};

      rst = 1'b1; cmd_ack = 1'b0; ca1_pulse = 1'b0; pa_i = 8'h00; rd0_cnt = 0;
      req0_valid = 1'b0; req0_rw = 1'b1; req0_addr = 2'd0; req0_wdata = 8'h00;
      req1_valid = 1'b0; req1_rw = 1'b1; req1_addr = 2'd0; req1_wdata = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cs", pia_cs, 0);
      check("rst_rw", pia_rw, 1);
      check("rst_addr", pia_addr, 0);
      check("rst_wdata", pia_wdata, 0);
      check("rst_init_done", init_done, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_overrun", cmd_overrun, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_rsp0", rsp0_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_init();

      // Table-driven requester accesses
      for (int i = 0; i < 6; i++) begin
         pa_i = req_tab[i].pa;
         do_req(req_tab[i].port, req_tab[i].rw, req_tab[i].addr, req_tab[i].wdata, req_tab[i].exp_rd);
         check("tab_pb", pb_o, req_tab[i].exp_pb);
      end

      // Both requesters at once: req0 write A5 then read, req1 read
      begin : pair
         int g0a, g0b, g1, n0;
         logic [7:0] rd1, rd0b;
         logic s0, s1;
         g0a = -1; g0b = -1; g1 = -1; n0 = 0; rd1 = 8'h00; rd0b = 8'h00;
         req0_rw = 1'b0; req0_addr = 2'd2; req0_wdata = 8'hA5; req0_valid = 1'b1;
         req1_rw = 1'b1; req1_addr = 2'd2; req1_wdata = 8'h00; req1_valid = 1'b1;
         for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            s0 = req0_ready; s1 = req1_ready;
            if (s0) begin
               if (n0 == 0) g0a = cyc; else g0b = cyc;
               n0++;
            end
            if (s1) g1 = cyc;
            if (rsp1_valid) rd1 = rsp_rdata;
            if (rsp0_valid && n0 == 2) rd0b = rsp_rdata;
            @(posedge clk); #1;
            if (s0) begin
               if (n0 == 1) req0_rw = 1'b1;
               else req0_valid = 1'b0;
            end
            if (s1) req1_valid = 1'b0;
         end
         req0_valid = 1'b0; req1_valid = 1'b0;
         check("pair_g0_first", g0a, 0);
         check("pair_g1", g1, 3);
         check("pair_g0_second", g0b, 6);
         check("pair_pb", pb_o, 8'hA5);
         check("pair_rsp1_rdata", rd1, 8'hA5);
         check("pair_rsp0_rdata", rd0b, 8'hA5);
      end

      // Single IRQ: exactly one port A read, command 5C
      base = rd0_cnt;
      pulse_ca1(8'h5C);
      wait_irq_read(seen);
      @(negedge clk);
      check("irq_irqa_low", pia_irqa, 0);
      check("irq_cmd_valid", cmd_valid, 1);
      check("irq_cmd_data", cmd_data, 8'h5C);
      check("irq_overrun", cmd_overrun, 0);
      repeat (6) @(negedge clk);
      check("irq_single_read", rd0_cnt - base, 1);

      // Capture and ack on the same edge: capture wins, no overrun
      pulse_ca1(8'h77);
      wait_irq_read(seen);
      cmd_ack = 1'b1;
      @(posedge clk); #1;
      cmd_ack = 1'b0;
      @(negedge clk);
      check("same_edge_valid", cmd_valid, 1);
      check("same_edge_overrun", cmd_overrun, 0);
      check("same_edge_data", cmd_data, 8'h77);

      // Two unacked commands: overrun, last data kept, then ack clears
      pulse_ca1(8'h11);
      wait_irq_read(seen);
      pulse_ca1(8'h22);
      wait_irq_read(seen);
      @(negedge clk);
      check("ovr_data", cmd_data, 8'h22);
      check("ovr_flag", cmd_overrun, 1);
      check("ovr_valid", cmd_valid, 1);
      @(posedge clk); #1;
      cmd_ack = 1'b1;
      @(posedge clk); #1;
      cmd_ack = 1'b0;
      @(negedge clk);
      check("ack_valid_clr", cmd_valid, 0);
      check("ack_overrun_clr", cmd_overrun, 0);
      @(posedge clk); #1;

      // CRA DDR-select cleared by a requester suppresses IRQ service
      do_req(0, 1'b0, 2'd1, 8'h00, 8'h00);
      base = rd0_cnt;
      pulse_ca1(8'h9E);
      repeat (8) @(negedge clk);
      check("shadow_no_read_00", rd0_cnt - base, 0);
      @(posedge clk); #1;
      do_req(0, 1'b0, 2'd1, 8'h39, 8'h00);
      repeat (6) @(negedge clk);
      check("shadow_irqa_pending", pia_irqa, 1);
      check("shadow_no_read_39", rd0_cnt - base, 0);
      @(posedge clk); #1;
      do_req(0, 1'b0, 2'd1, 8'h3D, 8'h00);
      wait_irq_read(seen);
      @(negedge clk);
      check("shadow_serviced_data", cmd_data, 8'h9E);
      check("shadow_serviced_valid", cmd_valid, 1);
      check("shadow_serviced_ovr", cmd_overrun, 0);
      @(posedge clk); #1;

      // Reset in the middle of a requester access
      begin : mid_reset
         logic got;
         got = 1'b0;
         req0_rw = 1'b0; req0_addr = 2'd2; req0_wdata = 8'h5F; req0_valid = 1'b1;
         for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (req0_ready) begin
               got = 1'b1;
               break;
            end
         end
         check("mr_grant", got, 1);
         @(posedge clk); #1;
         req0_valid = 1'b0;
         @(negedge clk);
         check("mr_cs_before", pia_cs, 1);
         rst = 1'b1;
         #1;
         check("mr_cs_drop", pia_cs, 0);
         check("mr_rw", pia_rw, 1);
         check("mr_rsp0", rsp0_valid, 0);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mr_rsp0_hold", rsp0_valid, 0);
            check("mr_init_done", init_done, 0);
         end
         @(posedge clk); #1;
         rst = 1'b0;
         check_init();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
